// File: rtl/instruction_fetch_queue.sv
// MIPS fetch stage: drives a 1-cycle synchronous instruction RAM and buffers returned
// words with their PCs in a DEPTH-entry queue. Supports redirect flush and a halt word.
module instruction_fetch_queue #(
    parameter int              len       = 32,
    parameter int              ADDR_W    = 11,
    parameter int              DEPTH     = 4,
    parameter logic [len-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 in_pc_src,
    input  logic [len-1:0]             in_pc_jump,
    input  logic [len-1:0]             in_pc_branch,
    input  logic [len-1:0]             in_pc_register,
    input  logic                       in_ready,
    output logic                       imem_en,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [len-1:0]             imem_rdata,
    output logic                       out_valid,
    output logic [len-1:0]             out_instruction,
    output logic [len-1:0]             out_pc,
    output logic [len-1:0]             out_pc_branch,
    output logic                       out_halt,
    output logic [$clog2(DEPTH):0]     out_count
);

    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(DEPTH);

    logic [len-1:0] fpc_q, fpc_d;
    logic [len-1:0] ifl_pc_q, ifl_pc_d;
    logic           ifl_q, ifl_d;
    logic           halted_q, halted_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [len-1:0] instr_q [DEPTH];
    logic [len-1:0] pc_q    [DEPTH];

    logic           redirect;
    logic           push;
    logic           pop;
    logic           halt_hit;
    logic           issue;
    logic [len-1:0] target;
    logic [CW:0]    credit;

    assign redirect = |in_pc_src;

    always_comb begin
        target = in_pc_register;
        if (in_pc_src[0]) begin
            target = in_pc_jump;
        end else if (in_pc_src[1]) begin
            target = in_pc_branch;
        end
    end

    // Credit includes the outstanding read so a returning word always has a free slot.
    assign credit   = {1'b0, count_q} + {{CW{1'b0}}, ifl_q};
    assign push     = ifl_q && !redirect;
    assign halt_hit = push && (imem_rdata == HALT_WORD);
    assign pop      = (count_q != '0) && in_ready && !redirect;
    assign issue    = !reset && !halted_q && !redirect && !halt_hit && (credit < CREDIT_MAX);

    always_comb begin
        fpc_d    = fpc_q;
        ifl_d    = issue;
        ifl_pc_d = issue ? fpc_q : ifl_pc_q;
        halted_d = halted_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (redirect) begin
            fpc_d    = target;
            halted_d = 1'b0;
            head_d   = tail_q;
            count_d  = '0;
        end else begin
            if (issue) begin
                fpc_d = fpc_q + len'(1);
            end
            if (halt_hit) begin
                halted_d = 1'b1;
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q    <= '0;
            ifl_q    <= 1'b0;
            halted_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            ifl_q    <= ifl_d;
            halted_q <= halted_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; visibility is gated by count.
    always_ff @(posedge clk) begin
        ifl_pc_q <= ifl_pc_d;
        if (push) begin
            instr_q[tail_q] <= imem_rdata;
            pc_q[tail_q]    <= ifl_pc_q;
        end
    end

    assign imem_en         = issue;
    assign imem_addr       = fpc_q[ADDR_W-1:0];
    assign out_valid       = (count_q != '0);
    assign out_instruction = out_valid ? instr_q[head_q] : '0;
    assign out_pc          = out_valid ? pc_q[head_q] : '0;
    assign out_pc_branch   = out_valid ? (pc_q[head_q] + len'(1)) : '0;
    assign out_halt        = halted_q;
    assign out_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with a 1-cycle synchronous RAM model.
module tb_instruction_fetch_queue;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_pc_src;
    logic [31:0] in_pc_jump;
    logic [31:0] in_pc_branch;
    logic [31:0] in_pc_register;
    logic        in_ready;
    logic        imem_en;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_branch;
    logic        out_halt;
    logic [2:0]  out_count;

    logic [31:0] ram [2048];
    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch_queue dut (
        .clk(clk), .reset(reset), .in_pc_src(in_pc_src), .in_pc_jump(in_pc_jump),
        .in_pc_branch(in_pc_branch), .in_pc_register(in_pc_register), .in_ready(in_ready),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_instruction(out_instruction), .out_pc(out_pc),
        .out_pc_branch(out_pc_branch), .out_halt(out_halt), .out_count(out_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= ram[imem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: first cycle with reset low.
    task automatic do_reset();
        reset = 1'b1;
        in_pc_src = 3'b000;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    // Ends in cycle 9 with PCs 5,6,7 queued and PC 8 in flight.
    task automatic prep_q567();
        in_ready = 1'b1;
        do_reset();
        repeat (7) step();
        in_ready = 1'b0;
        step();
        step();
        n_tests++;
        if ({out_count, out_pc, imem_en} !== {3'd3, 32'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL prep_q567: got cnt=%0d pc=%0h en=%b want cnt=3 pc=5 en=0",
                     out_count, out_pc, imem_en);
        end
    endtask

    task automatic test_reset();
        in_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        n_tests++;
        if ({imem_en, out_valid, out_count, out_halt, out_pc, out_instruction, out_pc_branch} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b v=%b cnt=%0d h=%b pc=%0h ins=%0h pcb=%0h want all 0",
                     imem_en, out_valid, out_count, out_halt, out_pc, out_instruction, out_pc_branch);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        in_ready = 1'b1;
        do_reset();
        n_tests++;
        if ({imem_en, imem_addr, out_valid} !== {1'b1, 11'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL seq_c0: got en=%b addr=%0h v=%b want en=1 addr=0 v=0", imem_en, imem_addr, out_valid);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_c1_valid: got %b want 0", out_valid);
        end
        for (int k = 2; k < 10; k++) begin
            step();
            e = 32'(k - 2);
            n_tests++;
            if ({out_valid, out_pc, out_instruction, out_pc_branch, out_count} !==
                {1'b1, e, 32'h1000_0000 + e, e + 32'd1, 3'd1}) begin
                n_fail++;
                $display("FAIL seq_c%0d: got v=%b pc=%0h ins=%0h pcb=%0h cnt=%0d want v=1 pc=%0h ins=%0h pcb=%0h cnt=1",
                         k, out_valid, out_pc, out_instruction, out_pc_branch, out_count,
                         e, 32'h1000_0000 + e, e + 32'd1);
            end
        end
    endtask

    task automatic test_backpressure();
        in_ready = 1'b0;
        do_reset();
        repeat (7) step();
        n_tests++;
        if ({out_count, imem_en, out_pc} !== {3'd4, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL bp_full: got cnt=%0d en=%b pc=%0h want cnt=4 en=0 pc=0", out_count, imem_en, out_pc);
        end
        in_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if ({out_valid, out_pc} !== {1'b1, 32'(k)}) begin
                n_fail++;
                $display("FAIL bp_drain%0d: got v=%b pc=%0h want v=1 pc=%0h", k, out_valid, out_pc, k);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        prep_q567();
        in_ready = 1'b1;
        in_pc_jump = 32'h99;
        in_pc_branch = 32'h40;
        in_pc_src = 3'b010;
        #1;
        n_tests++;
        if (imem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_noissue: got en=%b want 0", imem_en);
        end
        step();
        in_pc_src = 3'b000;
        #1;
        n_tests++;
        if ({out_valid, out_count, imem_en, imem_addr} !== {1'b0, 3'd0, 1'b1, 11'h40}) begin
            n_fail++;
            $display("FAIL redir_n1: got v=%b cnt=%0d en=%b addr=%0h want v=0 cnt=0 en=1 addr=40",
                     out_valid, out_count, imem_en, imem_addr);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_n2_valid: got %b want 0", out_valid);
        end
        step();
        n_tests++;
        if ({out_valid, out_pc, out_instruction, out_pc_branch} !== {1'b1, 32'h40, 32'h1000_0040, 32'h41}) begin
            n_fail++;
            $display("FAIL redir_n3: got v=%b pc=%0h ins=%0h pcb=%0h want v=1 pc=40 ins=10000040 pcb=41",
                     out_valid, out_pc, out_instruction, out_pc_branch);
        end
        step();
        n_tests++;
        if ({out_valid, out_pc} !== {1'b1, 32'h41}) begin
            n_fail++;
            $display("FAIL redir_n4: got v=%b pc=%0h want v=1 pc=41", out_valid, out_pc);
        end
    endtask

    task automatic test_priority();
        in_ready = 1'b1;
        do_reset();
        repeat (3) step();
        in_pc_jump = 32'h10;
        in_pc_branch = 32'h20;
        in_pc_register = 32'h30;
        in_pc_src = 3'b111;
        step();
        in_pc_src = 3'b000;
        #1;
        n_tests++;
        if ({imem_en, imem_addr} !== {1'b1, 11'h10}) begin
            n_fail++;
            $display("FAIL prio_addr: got en=%b addr=%0h want en=1 addr=10", imem_en, imem_addr);
        end
        step();
        step();
        n_tests++;
        if ({out_valid, out_pc} !== {1'b1, 32'h10}) begin
            n_fail++;
            $display("FAIL prio_pc: got v=%b pc=%0h want v=1 pc=10", out_valid, out_pc);
        end
    endtask

    task automatic test_halt();
        ram[3] = HALT;
        in_ready = 1'b1;
        do_reset();
        repeat (4) step();
        n_tests++;
        if ({imem_en, out_halt, out_pc} !== {1'b0, 1'b0, 32'd2}) begin
            n_fail++;
            $display("FAIL halt_h: got en=%b h=%b pc=%0h want en=0 h=0 pc=2", imem_en, out_halt, out_pc);
        end
        step();
        n_tests++;
        if ({out_halt, imem_en, out_valid, out_pc, out_instruction} !== {1'b1, 1'b0, 1'b1, 32'd3, HALT}) begin
            n_fail++;
            $display("FAIL halt_h1: got h=%b en=%b v=%b pc=%0h ins=%0h want h=1 en=0 v=1 pc=3 ins=ffffffff",
                     out_halt, imem_en, out_valid, out_pc, out_instruction);
        end
        step();
        step();
        step();
        n_tests++;
        if ({out_halt, imem_en, out_valid} !== {1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_hold: got h=%b en=%b v=%b want h=1 en=0 v=0", out_halt, imem_en, out_valid);
        end
        in_pc_jump = 32'h10;
        in_pc_branch = 32'h20;
        in_pc_register = 32'h8;
        in_pc_src = 3'b100;
        step();
        in_pc_src = 3'b000;
        #1;
        n_tests++;
        if ({out_halt, imem_en, imem_addr} !== {1'b0, 1'b1, 11'h8}) begin
            n_fail++;
            $display("FAIL halt_resume: got h=%b en=%b addr=%0h want h=0 en=1 addr=8", out_halt, imem_en, imem_addr);
        end
        step();
        step();
        n_tests++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h8, 32'h1000_0008}) begin
            n_fail++;
            $display("FAIL halt_resume_pc: got v=%b pc=%0h ins=%0h want v=1 pc=8 ins=10000008",
                     out_valid, out_pc, out_instruction);
        end
        ram[3] = 32'h1000_0003;
    endtask

    task automatic test_reset_midrun();
        prep_q567();
        reset = 1'b1;
        step();
        n_tests++;
        if ({out_valid, out_count, out_halt, imem_en, imem_addr, out_pc, out_instruction, out_pc_branch} !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: got v=%b cnt=%0d h=%b en=%b addr=%0h pc=%0h want all 0",
                     out_valid, out_count, out_halt, imem_en, imem_addr, out_pc);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({imem_en, imem_addr} !== {1'b1, 11'd0}) begin
            n_fail++;
            $display("FAIL midrst_c0: got en=%b addr=%0h want en=1 addr=0", imem_en, imem_addr);
        end
        step();
        n_tests++;
        if ({out_valid, out_count} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL midrst_c1: got v=%b cnt=%0d want v=0 cnt=0", out_valid, out_count);
        end
        step();
        n_tests++;
        if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'd0, 32'h1000_0000}) begin
            n_fail++;
            $display("FAIL midrst_c2: got v=%b pc=%0h ins=%0h want v=1 pc=0 ins=10000000",
                     out_valid, out_pc, out_instruction);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 32'h1000_0000 + 32'(i);
        reset = 1'b1;
        in_pc_src = 3'b000;
        in_pc_jump = '0;
        in_pc_branch = '0;
        in_pc_register = '0;
        in_ready = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_priority();
        test_halt();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

- Next-generation MIPS fetch stage with a parametrised prefetch queue.
- Drives a 1-cycle-latency synchronous instruction RAM and tags each returned word with its word-address PC.
- Buffers up to DEPTH instructions and hands them to decode over a valid/ready handshake.
- Replaces the single-register fetch path: adds redirect flush with in-flight kill, a programmable halt word and occupancy reporting.

## Interface
Parameters:
- len, 32, instruction and PC width.
- ADDR_W, 11, instruction RAM address width (word address).
- DEPTH, 4, queue entries; power of two, minimum 2.
- HALT_WORD, 32'hFFFF_FFFF, instruction value that stops fetching.

Ports (clock and reset first):
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- in_pc_src  in  3  redirect select: bit0 jump, bit1 branch, bit2 register; 3'b000 means sequential.
- in_pc_jump  in  len  jump target.
- in_pc_branch  in  len  branch target.
- in_pc_register  in  len  register (jr/jalr) target.
- in_ready  in  1  decode accepts head entry.
- imem_en  out  1  RAM read enable.
- imem_addr  out  ADDR_W  RAM word address, fpc[ADDR_W-1:0].
- imem_rdata  in  len  RAM data, valid the cycle after imem_en.
- out_valid  out  1  head entry valid.
- out_instruction  out  len  head instruction.
- out_pc  out  len  head instruction address.
- out_pc_branch  out  len  out_pc+1.
- out_halt  out  1  sticky; fetch stopped on HALT_WORD.
- out_count  out  $clog2(DEPTH)+1  queue occupancy.

## Operation
- State: fetch PC fpc, in-flight flag and PC (ifl, ifl_pc), circular queue with DEPTH entries {instr, pc}, head/tail pointers, count, halted.
- Issue: imem_en=1 iff !reset && !halted && in_pc_src==0 && count+ifl < DEPTH.
  - On issue: ifl<=1, ifl_pc<=fpc, fpc<=fpc+1 (mod 2^len). Otherwise ifl<=0.
- Response: in the cycle after issue (ifl=1), {imem_rdata, ifl_pc} is pushed at tail.
  - If imem_rdata==HALT_WORD, the word is still pushed, halted<=1, and no issue occurs that cycle.
- Pop: when out_valid && in_ready, head advances. Push and pop in the same cycle leave count unchanged.
- Redirect (in_pc_src!=0) is decided, not buffered:
  - clear queue (count<=0, head<=tail);
  - drop the in-flight response (ifl<=0, no push next cycle);
  - halted<=0;
  - fpc<=target with priority jump > branch > register;
  - no issue in the redirect cycle.
  - Redirect overrides a simultaneous pop, push and halt detection.
- Outputs: out_valid=(count!=0). out_instruction/out_pc/out_pc_branch come from the head entry and are forced to 0 whenever out_valid=0.
- Never overflows: the credit check counts in-flight reads. Pop while empty is ignored.

## Timing
- Reset values: all outputs 0, fpc=0, ifl=0, halted=0, queue empty.
- Reset asserted mid-operation clears everything at the next edge, including any in-flight read.
- First fetch: in the first cycle with reset low, imem_en=1 and imem_addr=0. Entry 0 is pushed at the end of cycle 1, so out_valid=1 from cycle 2.
- Redirect latency: redirect sampled in cycle N; issue at target in N+1; push in N+2; out_valid with out_pc=target in N+3.
- Throughput with in_ready held high and DEPTH≥3 is 1 instruction/cycle. DEPTH=2 gives 1 per 2 cycles.
- With in_ready=0, issue stops once count+ifl reaches DEPTH. Exactly DEPTH entries are held, with no loss.
- Halt: HALT_WORD arrives in cycle H. out_halt=1 and imem_en=0 from H+1 until reset or redirect. Queued entries ahead of and including HALT_WORD remain poppable.

## Test plan
- Sequential run: RAM[i]=0x1000_0000+i, in_ready=1, DEPTH=4 -> out_valid from cycle 2; one entry per cycle with out_pc=0,1,2…; out_pc_branch=out_pc+1; out_count settles at 1.
- Backpressure: in_ready=0 from cycle 0 -> out_count reaches 4, imem_en drops to 0. Releasing in_ready then yields PCs 0..3 in order with no duplicates or gaps.
- Redirect with in-flight kill: queue holding PCs 5..7, in_pc_src=3'b010, in_pc_branch=0x40 -> out_valid=0 for the next two cycles, then out_pc=0x40; no 5..7 or stale in-flight word appears.
- Priority: in_pc_src=3'b111 with jump=0x10, branch=0x20, register=0x30 -> first out_pc=0x10.
- Halt: RAM[3]=HALT_WORD -> PCs 0..3 delivered, out_halt=1, imem_en stays 0. A later in_pc_src=3'b100 with register=0x8 clears out_halt and resumes at 0x8.
- Reset mid-run: assert reset for 1 cycle while out_count=3 and ifl=1 -> all outputs 0 the next cycle, then restart at PC 0 with the cycle-2 first-valid timing.
